// File: rtl/alu_frame_sequencer.sv
// UART frame sequencer for the shared ALU: parses HEADER,A,B,OP[,CHK], strobes the ALU, returns status+result.
// Optional checksum byte enabled by defining SEQ_CHECKSUM_EN.
module alu_frame_sequencer #(
    parameter int                  NB_DATA        = 8,
    parameter int                  NB_OP          = 6,
    parameter logic [NB_DATA-1:0]  HEADER         = 8'hA5,
    parameter int                  TIMEOUT_CYCLES = 100000
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    output logic [NB_DATA-1:0] o_alu_data_a,
    output logic [NB_DATA-1:0] o_alu_data_b,
    output logic [NB_OP-1:0]   o_alu_op,
    output logic               o_alu_valid,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    input  logic               i_tx_done,
    output logic               o_busy,
    output logic               o_err
);

    localparam int                 NB_CNT     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [NB_DATA-1:0] STATUS_OK  = '0;
    localparam logic [NB_DATA-1:0] STATUS_CHK = NB_DATA'(8'hE1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_GET_A,
        S_GET_B,
        S_GET_OP,
        S_EXEC,
        S_CAPTURE,
        S_TX_STATUS,
        S_TX_RESULT
`ifdef SEQ_CHECKSUM_EN
        , S_GET_CHK
`endif
    } state_t;

    state_t             state_q, state_d;
    logic [NB_DATA-1:0] a_q, a_d, b_q, b_d;
    logic [NB_OP-1:0]   op_q, op_d;
    logic               valid_q, valid_d;
    logic [NB_DATA-1:0] result_q, result_d;
    logic [NB_DATA-1:0] tx_data_q, tx_data_d;
    logic               tx_start_q, tx_start_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;
    logic [NB_CNT-1:0]  cnt_q, cnt_d;
    logic               chk_fail;
    logic               in_get;
    logic               timeout;

`ifdef SEQ_CHECKSUM_EN
    logic [NB_DATA-1:0] op_byte_q, op_byte_d;
    logic               chk_err_q, chk_err_d;
    assign chk_fail = chk_err_q;
    assign in_get   = (state_q == S_GET_A) || (state_q == S_GET_B) ||
                      (state_q == S_GET_OP) || (state_q == S_GET_CHK);
`else
    assign chk_fail = 1'b0;
    assign in_get   = (state_q == S_GET_A) || (state_q == S_GET_B) || (state_q == S_GET_OP);
`endif

    // A byte arriving in the expiry cycle wins over the timeout.
    assign timeout = in_get && !i_rx_done && (cnt_q == NB_CNT'(TIMEOUT_CYCLES));

    // NOTE: every *_d gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        result_d   = result_q;
        tx_data_d  = tx_data_q;
        valid_d    = 1'b0;
        tx_start_d = 1'b0;
        err_d      = 1'b0;
        cnt_d      = cnt_q;
`ifdef SEQ_CHECKSUM_EN
        op_byte_d  = op_byte_q;
        chk_err_d  = chk_err_q;
`endif
        if (in_get) begin
            cnt_d = i_rx_done ? '0 : cnt_q + NB_CNT'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (i_rx_done && (i_rx_data == HEADER)) begin
                    state_d = S_GET_A;
                    cnt_d   = '0;
`ifdef SEQ_CHECKSUM_EN
                    chk_err_d = 1'b0;
`endif
                end
            end
            S_GET_A: if (i_rx_done) begin
                a_d     = i_rx_data;
                state_d = S_GET_B;
            end
            S_GET_B: if (i_rx_done) begin
                b_d     = i_rx_data;
                state_d = S_GET_OP;
            end
            S_GET_OP: if (i_rx_done) begin
                op_d = i_rx_data[NB_OP-1:0];
`ifdef SEQ_CHECKSUM_EN
                op_byte_d = i_rx_data;
                state_d   = S_GET_CHK;
`else
                state_d   = S_EXEC;
                valid_d   = 1'b1;
`endif
            end
`ifdef SEQ_CHECKSUM_EN
            S_GET_CHK: if (i_rx_done) begin
                chk_err_d = (i_rx_data != (a_q ^ b_q ^ op_byte_q));
                err_d     = chk_err_d;
                state_d   = S_EXEC;
                valid_d   = 1'b1;
            end
`endif
            S_EXEC:    state_d = S_CAPTURE;
            S_CAPTURE: begin
                result_d   = i_alu_result;
                tx_data_d  = chk_fail ? STATUS_CHK : STATUS_OK;
                tx_start_d = 1'b1;
                state_d    = S_TX_STATUS;
            end
            // A tx_done coinciding with our own start pulse belongs to an earlier byte.
            S_TX_STATUS: if (i_tx_done && !tx_start_q) begin
                if (chk_fail) begin
                    state_d = S_IDLE;
                end else begin
                    tx_data_d  = result_q;
                    tx_start_d = 1'b1;
                    state_d    = S_TX_RESULT;
                end
            end
            S_TX_RESULT: if (i_tx_done && !tx_start_q) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase

        if (timeout) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
            cnt_d   = '0;
        end
        busy_d = (state_d != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            valid_q    <= 1'b0;
            result_q   <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
`ifdef SEQ_CHECKSUM_EN
            op_byte_q  <= '0;
            chk_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            valid_q    <= valid_d;
            result_q   <= result_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
`ifdef SEQ_CHECKSUM_EN
            op_byte_q  <= op_byte_d;
            chk_err_q  <= chk_err_d;
`endif
        end
    end

    assign o_alu_data_a = a_q;
    assign o_alu_data_b = b_q;
    assign o_alu_op     = op_q;
    assign o_alu_valid  = valid_q;
    assign o_tx_data    = tx_data_q;
    assign o_tx_start   = tx_start_q;
    assign o_busy       = busy_q;
    assign o_err        = err_q;

endmodule

// File: tb/tb_alu_frame_sequencer.sv
// Bench for alu_frame_sequencer: frame vector table, TX scoreboard, timeout/drop/reset sequences.
// Follows SEQ_CHECKSUM_EN the same way as the design.
module tb_alu_frame_sequencer;

    localparam int         TIMEOUT = 100;
    localparam logic [7:0] HDR     = 8'hA5;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b0;
    logic [7:0] i_rx_data = 8'h00;
    logic       i_rx_done = 1'b0;
    logic       i_tx_done = 1'b0;
    logic [7:0] o_alu_data_a, o_alu_data_b, i_alu_result, o_tx_data;
    logic [5:0] o_alu_op;
    logic       o_alu_valid, o_tx_start, o_busy, o_err;

    alu_frame_sequencer #(
        .NB_DATA(8), .NB_OP(6), .HEADER(HDR), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_rx_data(i_rx_data), .i_rx_done(i_rx_done),
        .o_alu_data_a(o_alu_data_a), .o_alu_data_b(o_alu_data_b),
        .o_alu_op(o_alu_op), .o_alu_valid(o_alu_valid),
        .i_alu_result(i_alu_result),
        .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .i_tx_done(i_tx_done),
        .o_busy(o_busy), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            default: return 8'h00;
        endcase
    endfunction

    assign i_alu_result = alu_model(o_alu_data_a, o_alu_data_b, o_alu_op);

    int         n_checks = 0;
    int         n_fail   = 0;
    int         err_seen = 0;
    int         exp_err  = 0;
    int         resp_mode  = 0;  // 0 normal, 1 spurious done in start cycle, 2 never answer
    int         resp_delay = 3;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_data = b;
        i_rx_done = 1'b1;
        tick();
        i_rx_done = 1'b0;
    endtask

    // TX side: scoreboard compare on every start pulse plus the tx_done responder.
    initial begin : tx_side
        int         wait_cnt;
        logic [7:0] held;
        wait_cnt = -1;
        held     = 8'h00;
        forever begin
            @(posedge i_clk);
            #1;
            if (o_err) err_seen++;
            if (i_rst) begin
                wait_cnt  = -1;
                i_tx_done = 1'b0;
            end else begin
                i_tx_done = 1'b0;
                if (o_tx_start) begin
                    check("tx_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) check("tx_byte", o_tx_data, exp_q.pop_front());
                    held = o_tx_data;
                    if (resp_mode != 2) begin
                        wait_cnt = resp_delay;
                        if (resp_mode == 1) i_tx_done = 1'b1;
                    end
                end else if (wait_cnt == 0) begin
                    check("tx_data_stable", o_tx_data, held);
                    i_tx_done = 1'b1;
                    wait_cnt  = -1;
                end else if (wait_cnt > 0) begin
                    if (resp_mode == 1 && wait_cnt == resp_delay)
                        check("early_done_ignored", {o_tx_start, o_busy}, 2'b01);
                    wait_cnt--;
                end
            end
        end
    end

    task automatic wait_idle();
        int k;
        k = 0;
        while ((o_busy || exp_q.size() != 0) && k < 300) begin
            tick();
            k++;
        end
        check("frame_done_in_budget", 32'(k < 300), 32'd1);
        repeat (3) tick();
        check("busy_low_end", o_busy, 1'b0);
    endtask

    task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                             input bit bad, input logic [7:0] exp_res, input bit inject);
        logic [7:0] chk;
        bit         bad_eff;
        chk = a ^ b ^ op;
`ifdef SEQ_CHECKSUM_EN
        bad_eff = bad;
        if (bad) chk = chk ^ 8'h01;
`else
        bad_eff = 1'b0;
`endif
        if (bad_eff) begin
            exp_q.push_back(8'hE1);
            exp_err++;
        end else begin
            exp_q.push_back(8'h00);
            exp_q.push_back(exp_res);
        end
        send_byte(HDR);
        tick();
        send_byte(a);
        send_byte(b);
        tick();
`ifdef SEQ_CHECKSUM_EN
        send_byte(op);
        send_byte(chk);
`else
        send_byte(op);
`endif
        check("alu_valid_n1", o_alu_valid, 1'b1);
        check("alu_a", o_alu_data_a, a);
        check("alu_b", o_alu_data_b, b);
        check("alu_op", o_alu_op, op[5:0]);
        check("err_pulse_n1", o_err, bad_eff);
        tick();
        check("alu_valid_one_cycle", {o_alu_valid, o_err}, 2'b00);
        tick();
        check("tx_start_n3", o_tx_start, 1'b1);
        if (inject) begin
            send_byte(8'h11);
            send_byte(8'h22);
        end
        wait_idle();
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] op;
        bit         bad;
        logic [7:0] res;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{8'h05, 8'h03, 8'h20, 1'b0, 8'h08};
        vecs[1] = '{8'h05, 8'h03, 8'h20, 1'b1, 8'h08};
        vecs[2] = '{8'hFF, 8'h01, 8'h20, 1'b0, 8'h00};
        vecs[3] = '{8'h0A, 8'h02, 8'h22, 1'b0, 8'h08};
        vecs[4] = '{8'hF0, 8'h3C, 8'h24, 1'b0, 8'h30};
        vecs[5] = '{8'hF0, 8'h3C, 8'h25, 1'b0, 8'hFC};
        vecs[6] = '{8'hA5, 8'hA5, 8'h26, 1'b0, 8'h00};
        vecs[7] = '{8'h12, 8'h34, 8'hE0, 1'b0, 8'h46};

        #1 i_rst = 1'b1;
        #1;
        check("reset_outputs", {o_alu_data_a, o_alu_data_b, o_alu_op, o_alu_valid,
                                o_tx_data, o_tx_start, o_busy, o_err}, '0);
        repeat (3) @(posedge i_clk);
        #1 i_rst = 1'b0;
        tick();

        send_byte(8'h00);
        send_byte(8'hFF);
        tick();
        check("idle_ignores_garbage", o_busy, 1'b0);

        foreach (vecs[i]) run_frame(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].bad, vecs[i].res, 1'b0);

        // Spurious tx_done in the start cycle must not advance the TX state.
        resp_mode = 1;
        run_frame(8'h2C, 8'h0F, 8'h24, 1'b0, 8'h0C, 1'b0);
        resp_mode = 0;

        // Bytes received while transmitting are dropped.
        resp_delay = 4;
        run_frame(8'h05, 8'h03, 8'h20, 1'b0, 8'h08, 1'b1);
        resp_delay = 3;

        // Timeout after TIMEOUT idle cycles in GET_B.
        send_byte(HDR);
        send_byte(8'h05);
        repeat (TIMEOUT) tick();
        check("no_err_before_expiry", {o_err, o_busy}, 2'b01);
        tick();
        check("timeout_err", {o_err, o_busy}, 2'b10);
        exp_err++;
        tick();
        check("timeout_err_one_cycle", o_err, 1'b0);
        repeat (5) tick();
        check("timeout_no_tx", 32'(exp_q.size()), 32'd0);

        // A byte landing in the expiry cycle wins over the timeout.
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h08);
        send_byte(HDR);
        send_byte(8'h05);
        repeat (TIMEOUT) tick();
        send_byte(8'h03);
        check("late_byte_wins", {o_err, o_busy}, 2'b01);
        send_byte(8'h20);
`ifdef SEQ_CHECKSUM_EN
        send_byte(8'h26);
`endif
        check("late_frame_exec", o_alu_valid, 1'b1);
        wait_idle();

        run_frame(8'hFF, 8'h01, 8'h20, 1'b0, 8'h00, 1'b0);

        // Reset while the status byte is pending.
        resp_mode = 2;
        exp_q.push_back(8'h00);
        send_byte(HDR);
        send_byte(8'h05);
        send_byte(8'h03);
        send_byte(8'h20);
`ifdef SEQ_CHECKSUM_EN
        send_byte(8'h26);
`endif
        tick();
        tick();
        tick();
        check("pre_reset_pending", {o_busy, o_alu_data_a, o_tx_data}, {1'b1, 8'h05, 8'h00});
        #2 i_rst = 1'b1;
        #1;
        check("reset_mid_tx_outputs", {o_alu_data_a, o_alu_data_b, o_alu_op, o_alu_valid,
                                       o_tx_data, o_tx_start, o_busy, o_err}, '0);
        repeat (2) @(posedge i_clk);
        #1 i_rst = 1'b0;
        resp_mode = 0;
        tick();
        run_frame(8'h0A, 8'h02, 8'h22, 1'b0, 8'h08, 1'b0);

        repeat (5) tick();
        check("err_pulse_count", 32'(err_seen), 32'(exp_err));
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
